// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing control for the 5-stage pipeline (F D E M W).
// Produces the E-stage operand forwarding selects, per-stage stall/flush
// enables, and runs the data-memory wait FSM with a timeout into a sticky error.
// Optional build macro HAZARD_PERF_EN adds the StallCycles/FlushCycles counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W    = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] StallCycles,
  output logic [PERF_W-1:0] FlushCycles,
`endif
  output logic        MemErr
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} mstate_e;

  mstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_stall, pc_pend, mem_stall;

  // R15 is never forwarded; M-stage result beats W-stage result.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       wem, input logic [3:0] wam,
                                         input logic       wew, input logic [3:0] waw);
    if (ra == 4'hF)                 return 2'b00;
    else if (wem && (wam == ra))    return 2'b10;
    else if (wew && (waw == ra))    return 2'b01;
    else                            return 2'b00;
  endfunction

  // Operand forwarding selects for the E-stage ALU.
  always_comb begin
    ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  // Combinational hazard detection: load-use and pending PC writes.
  always_comb begin
    ld_stall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
    pc_pend  = PCSrcD | PCSrcE | PCSrcM;
  end

  // Memory wait FSM state and timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory FSM next state; stall asserted in the request cycle itself so a
  // ready memory costs no extra cycles. Ready at the timeout cycle still wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = CW'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (cnt_q == CW'(MEM_TIMEOUT)) state_d = S_ERR;
          else                           cnt_d   = cnt_q + CW'(1);
        end
      end
      S_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall/flush enables; a memory stall freezes everything and bubbles only W.
  always_comb begin
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = ld_stall | pc_pend;
      StallD = ld_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = pc_pend | PCSrcW | BranchTakenE;
      FlushE = ld_stall | BranchTakenE;
      FlushW = 1'b0;
    end
  end

  assign MemErr = (state_q == S_ERR);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Free-running, wrapping occupancy counters for stalls and flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF)           stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (FlushD || FlushE) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4): directed vectors with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCycles;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
`ifdef HAZARD_PERF_EN
    .StallCycles(StallCycles), .FlushCycles(FlushCycles),
`endif
    .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  // Memory side is tracked as "number of consecutive not-ready cycles of the
  // current access" plus a sticky error bit.
  bit        m_err, m_busy;
  int        m_n;
  int unsigned m_stalls, m_flushes;
  logic [1:0] e_fa, e_fb;
  logic       e_ms, e_ld, e_pc;
  logic       e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

  function automatic logic [1:0] mfwd(input logic [3:0] r);
    logic [1:0] s;
    s = 2'd0;
    if (r != 4'd15) begin
      if (RegWriteW && WA3W == r) s = 2'd1;
      if (RegWriteM && WA3M == r) s = 2'd2;
    end
    return s;
  endfunction

  always_comb begin
    e_fa = mfwd(RA1E);
    e_fb = mfwd(RA2E);
    e_ld = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    e_pc = PCSrcD || PCSrcE || PCSrcM;
    e_ms = m_err || (!MemReadyM && (m_busy || MemReqM));
    e_sf = e_ms ? 1'b1 : (e_ld || e_pc);
    e_sd = e_ms ? 1'b1 : e_ld;
    e_se = e_ms;
    e_sm = e_ms;
    e_fw = e_ms;
    e_fd = e_ms ? 1'b0 : (e_pc || PCSrcW || BranchTakenE);
    e_fe = e_ms ? 1'b0 : (e_ld || BranchTakenE);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_err <= 1'b0; m_busy <= 1'b0; m_n <= 0;
      m_stalls <= 0; m_flushes <= 0;
    end else begin
      if (!m_err) begin
        if (!MemReadyM && (m_busy || MemReqM)) begin
          m_busy <= 1'b1;
          m_n    <= m_n + 1;
          if (m_n + 1 > TO) m_err <= 1'b1;
        end else begin
          m_busy <= 1'b0;
          m_n    <= 0;
        end
      end
      if (e_sf) m_stalls <= m_stalls + 1;
      if (e_fd || e_fe) m_flushes <= m_flushes + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ForwardAE", ForwardAE, e_fa);
      chk("m_ForwardBE", ForwardBE, e_fb);
      chk("m_stalls", {StallF, StallD, StallE, StallM}, {e_sf, e_sd, e_se, e_sm});
      chk("m_flushes", {FlushD, FlushE, FlushW}, {e_fd, e_fe, e_fw});
      chk("m_MemErr", MemErr, m_err);
`ifdef HAZARD_PERF_EN
      chk("m_StallCycles", StallCycles, m_stalls);
      chk("m_FlushCycles", FlushCycles, m_flushes);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    WA3E = 4'd1;  // avoid spurious load-use match on zeroed registers
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rst_MemErr", MemErr, 0);
    chk("rst_StallF", StallF, 0);

    // Forwarding priority
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 3;
    settle();
    chk("fwd_M_A", ForwardAE, 2'b10);
    chk("fwd_M_B", ForwardBE, 2'b10);
    tick(); RegWriteM = 0; settle();
    chk("fwd_W_A", ForwardAE, 2'b01);
    tick(); RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; settle();
    chk("fwd_R15_A", ForwardAE, 2'b00);

    // Load-use
    tick(); clr(); MemtoRegE = 1; WA3E = 5; RA1D = 1; RA2D = 5; settle();
    chk("ld_hit", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    tick(); RA2D = 6; settle();
    chk("ld_miss", {StallF, StallD, FlushE, FlushD}, 4'b0000);

    // Branch / PC write
    tick(); clr(); WA3E = 1; BranchTakenE = 1; settle();
    chk("br_taken", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    tick(); BranchTakenE = 0; PCSrcD = 1; settle();
    chk("pcsrcD", {StallF, FlushD, FlushE}, 3'b110);

    // Memory wait: 3 not-ready cycles then ready
    tick(); clr(); WA3E = 1; MemReqM = 1;
    for (int c = 1; c <= 3; c++) begin
      BranchTakenE = (c == 2);
      settle();
      chk("mw_stall", {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
      if (c == 2) chk("mw_br_FlushE", FlushE, 0);
      tick();
    end
    BranchTakenE = 0; MemReadyM = 1; settle();
    chk("mw_release", {StallF, StallD, StallE, StallM, FlushW}, 5'b00000);

    // Timeout into sticky error
    tick(); MemReadyM = 0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      chk("to_noerr", MemErr, 0);
      tick();
    end
    settle();
    chk("to_err", MemErr, 1);
    tick(); MemReqM = 0; MemReadyM = 1; settle();
    chk("to_sticky", {MemErr, StallF, StallM}, 3'b111);
    tick(); reset = 1;
    tick(); reset = 0; MemReadyM = 0; settle();
    chk("to_rst_clear", {MemErr, StallF, StallM, FlushW}, 4'b0000);

`ifdef HAZARD_PERF_EN
    chk("perf_rst_stall", StallCycles, 0);
    chk("perf_rst_flush", FlushCycles, 0);
    tick(); MemReqM = 1;
    repeat (3) tick();
    MemReadyM = 1;
    tick(); clr(); WA3E = 1; BranchTakenE = 1;
    tick(); BranchTakenE = 0;
    settle();
    chk("perf_stall", StallCycles, 3);
    chk("perf_flush", FlushCycles, 1);
`endif

    // A few mixed vectors to exercise the model further
    tick(); clr(); WA3E = 7; MemtoRegE = 1; RA1D = 7; PCSrcW = 1; RegWriteW = 1; WA3W = 2; RA2E = 2;
    tick(); clr(); WA3E = 1; PCSrcM = 1; RegWriteM = 1; WA3M = 4; RA1E = 4; RA2E = 4;
    tick(); clr(); WA3E = 1; MemReqM = 1; MemReadyM = 1; PCSrcE = 1;
    tick(); clr(); WA3E = 1;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined processor (F, D, E, M, W).
- Generates the forwarding selects for the E-stage ALU operands, plus the stall and flush enables for every pipeline register.
- Load-use, PC-write and branch hazards are detected combinationally.
- Owns the registered data-memory wait FSM with a timeout counter, so the pipeline can stall on a multi-cycle memory.

Parameters:
- MEM_TIMEOUT, 16: max consecutive wait cycles allowed for one M-stage access before the error state.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RA1D, RA2D  input  4 each  source registers of the instruction in D.
- RA1E, RA2E  input  4 each  source registers of the instruction in E.
- WA3E, WA3M, WA3W  input  4 each  destination registers in E, M, W.
- RegWriteM, RegWriteW  input  1 each  register write enables in M and W.
- MemtoRegE  input  1  instruction in E is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1 each  instruction in that stage writes R15.
- BranchTakenE  input  1  branch resolved taken in E.
- MemReqM  input  1  M-stage instruction accesses data memory (load or store).
- MemReadyM  input  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  output  2 each  operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM  output  1 each  hold the pipeline register feeding that stage.
- FlushD, FlushE, FlushW  output  1 each  clear that pipeline register to a bubble.
- MemErr  output  1  sticky memory-timeout error.

Behaviour:
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM and WA3M == RA1E.
  - Else 01 if RegWriteW and WA3W == RA1E.
  - Else 00.
  - M has priority over W.
  - No forwarding when the matching register is 4'hF.
- ForwardBE: identical rule using RA2E.
- LdStall = MemtoRegE & (RA1D == WA3E | RA2D == WA3E).
- PCPend = PCSrcD | PCSrcE | PCSrcM.
- Memory FSM states: RUN (reset state), WAIT, ERR.
  - RUN -> WAIT when MemReqM & !MemReadyM; the counter is loaded with 1.
  - WAIT -> RUN when MemReadyM; the counter is cleared.
  - WAIT -> ERR when the counter == MEM_TIMEOUT and !MemReadyM. MemReadyM in that same cycle wins, giving WAIT -> RUN.
  - In WAIT the counter otherwise increments by 1 per cycle.
  - ERR is absorbing until reset.
  - Counter width is clog2(MEM_TIMEOUT+1); it never wraps.
- MemStall = (RUN & MemReqM & !MemReadyM) | (WAIT & !MemReadyM) | ERR.
  - Combinational in the request cycle, so there are zero extra cycles when memory is ready.
- Outputs when MemStall = 1:
  - StallF = StallD = StallE = StallM = 1.
  - FlushW = 1, so W does not repeat a writeback.
  - FlushD = FlushE = 0: frozen stages are not bubbled; E re-evaluates when released.
- Outputs when MemStall = 0:
  - StallF = LdStall | PCPend.
  - StallD = LdStall.
  - StallE = StallM = FlushW = 0.
  - FlushD = PCPend | PCSrcW | BranchTakenE.
  - FlushE = LdStall | BranchTakenE.
- MemErr = 1 exactly when state is ERR.
- Reset effects:
  - State -> RUN, counter -> 0, MemErr -> 0.
  - Outputs revert to the combinational functions of the inputs on the next cycle.
  - A reset during WAIT abandons the access.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds output ports StallCycles and FlushCycles, each PERF_W bits.
  - StallCycles increments every cycle StallF = 1.
  - FlushCycles increments every cycle FlushD | FlushE = 1.
  - Both wrap modulo 2^PERF_W and clear on reset.
- Undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Forwarding priority: RegWriteM = 1, WA3M = 3, RegWriteW = 1, WA3W = 3, RA1E = 3 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. RA1E = 15 with the same matches -> ForwardAE = 00.
- Load-use: MemtoRegE = 1, WA3E = 5, RA2D = 5 -> StallF = StallD = FlushE = 1, FlushD = 0. Same with RA2D = 6 -> all 0.
- Branch taken: BranchTakenE = 1 -> FlushD = FlushE = 1, no stalls. PCSrcD = 1 alone -> StallF = FlushD = 1.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles then 1 -> all four stalls and FlushW high for exactly 3 cycles, then released. BranchTakenE = 1 during the wait -> FlushE stays 0.
- Timeout: MEM_TIMEOUT = 4, MemReadyM held 0 -> MemErr = 1 from the 6th cycle after the request and stays 1 with MemReadyM = 1. One-cycle reset -> MemErr = 0, stalls drop.
- With HAZARD_PERF_EN: 3-cycle memory wait plus 1 branch flush -> StallCycles = 3, FlushCycles = 1. Counters read 0 after reset.
